pwm_top: RTL and testbench

//  Single-channel PWM generator with complementary outputs (out / nOut), for LED dimming
//  or half-bridge drive. Derives the PWM period from the system clock and a target PWM

---
 rtl/pwm_top.sv | 66 ++++++
 tb/tb_pwm_top.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_top.sv
// Single-channel PWM with complementary registered outputs.
// Period derives from CLK_FREQ/FREQUENCY; duty is D/256 of that period.
module pwm_top #(
  parameter int CLK_FREQ  = 12_000_000,
  parameter int FREQUENCY = 1_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] dutyCycle,
  output logic       out,
  output logic       nOut
);

  localparam int PERIOD = CLK_FREQ / FREQUENCY;
  localparam int CW = (PERIOD < 2) ? 1 : $clog2(PERIOD);
  localparam int PW = 8 + CW;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  localparam logic [PW-1:0] PER_W = PW'(PERIOD);

  if (PERIOD < 2) begin : g_bad_period
    $error("pwm_top: PERIOD must be at least 2");
  end

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [CW-1:0] thr;
  logic [CW-1:0] thr_next;
  logic [CW-1:0] thr_calc;
  logic [PW-1:0] prod;
  logic          run;
  logic          wrap;
  logic          load;
  logic          out_next;

  // next-state: counter wrap, duty latch at period start, output compare
  always_comb begin
    wrap     = (cnt == LAST);
    load     = enable & (~run | wrap);
    cnt_next = '0;
    if (enable & run & ~wrap)
      cnt_next = cnt + 1'b1;
    prod     = PW'(dutyCycle) * PER_W;
    thr_calc = CW'(prod >> 8);
    thr_next = load ? thr_calc : thr;
    out_next = enable & (cnt_next < thr_next);
  end

  // state and registered complementary outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      thr  <= '0;
      run  <= 1'b0;
      out  <= 1'b0;
      nOut <= 1'b1;
    end else begin
      cnt  <= cnt_next;
      thr  <= thr_next;
      run  <= enable;
      out  <= out_next;
      nOut <= ~out_next;
    end
  end

endmodule

// File: tb/tb_pwm_top.sv
// Directed bench for pwm_top at PERIOD=12 (12 MHz / 1 MHz).
// Samples on the falling edge, drives inputs right after it.
module tb_pwm_top;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] dutyCycle;
  logic       out;
  logic       nOut;

  int tests;
  int fails;

  pwm_top #(
    .CLK_FREQ (12_000_000),
    .FREQUENCY(1_000_000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .dutyCycle(dutyCycle),
    .out      (out),
    .nOut     (nOut)
  );

  initial begin
    clk = 1'b0;
    forever #42 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic exp_out(int k, int high);
    return ((k % 12) < high) ? 1'b1 : 1'b0;
  endfunction

  task automatic go_idle();
    enable = 1'b0;
    tick();
    tests++;
    if (out !== 1'b0 || nOut !== 1'b1) begin
      fails++;
      $display("FAIL idle: out=%b nOut=%b want out=0 nOut=1", out, nOut);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    enable = 1'b0;
    dutyCycle = 8'd0;
    tick();
    tick();
    tests++;
    if (out !== 1'b0 || nOut !== 1'b1) begin
      fails++;
      $display("FAIL reset_hold: out=%b nOut=%b want 0/1", out, nOut);
    end
    rst = 1'b1;
    tick();
    tests++;
    if (out !== 1'b0 || nOut !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_idle: out=%b nOut=%b want 0/1", out, nOut);
    end
  endtask

  task automatic test_d50();
    go_idle();
    dutyCycle = 8'd50;
    enable = 1'b1;
    for (int k = 0; k < 36; k++) begin
      tick();
      tests++;
      if (out !== exp_out(k, 2) || nOut !== ~exp_out(k, 2)) begin
        fails++;
        $display("FAIL d50 cyc%0d: out=%b nOut=%b want out=%b",
                 k, out, nOut, exp_out(k, 2));
      end
    end
  endtask

  task automatic test_d128_change();
    go_idle();
    dutyCycle = 8'd128;
    enable = 1'b1;
    for (int k = 0; k < 24; k++) begin
      tick();
      tests++;
      if (out !== exp_out(k, 6) || nOut !== ~exp_out(k, 6)) begin
        fails++;
        $display("FAIL d128 cyc%0d: out=%b nOut=%b want out=%b",
                 k, out, nOut, exp_out(k, 6));
      end
    end
    go_idle();
    dutyCycle = 8'd50;
    enable = 1'b1;
    for (int k = 0; k < 24; k++) begin
      logic e;
      tick();
      e = (k < 12) ? exp_out(k, 2) : exp_out(k, 6);
      tests++;
      if (out !== e || nOut !== ~e) begin
        fails++;
        $display("FAIL midchange cyc%0d: out=%b nOut=%b want out=%b",
                 k, out, nOut, e);
      end
      if (k == 4)
        dutyCycle = 8'd128;
    end
  endtask

  task automatic test_extremes();
    go_idle();
    dutyCycle = 8'd0;
    enable = 1'b1;
    for (int k = 0; k < 24; k++) begin
      tick();
      tests++;
      if (out !== 1'b0 || nOut !== 1'b1) begin
        fails++;
        $display("FAIL d0 cyc%0d: out=%b nOut=%b want 0/1", k, out, nOut);
      end
    end
    go_idle();
    dutyCycle = 8'd255;
    enable = 1'b1;
    for (int k = 0; k < 24; k++) begin
      tick();
      tests++;
      if (out !== exp_out(k, 11) || nOut !== ~exp_out(k, 11)) begin
        fails++;
        $display("FAIL d255 cyc%0d: out=%b nOut=%b want out=%b",
                 k, out, nOut, exp_out(k, 11));
      end
    end
  endtask

  task automatic test_enable();
    go_idle();
    dutyCycle = 8'd128;
    enable = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    tests++;
    if (out !== 1'b1) begin
      fails++;
      $display("FAIL en_high_phase: out=%b want 1", out);
    end
    enable = 1'b0;
    tick();
    tests++;
    if (out !== 1'b0 || nOut !== 1'b1) begin
      fails++;
      $display("FAIL en_drop: out=%b nOut=%b want 0/1", out, nOut);
    end
    tick();
    tick();
    enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      tests++;
      if (out !== exp_out(k, 6) || nOut !== ~exp_out(k, 6)) begin
        fails++;
        $display("FAIL en_restart cyc%0d: out=%b nOut=%b want out=%b",
                 k, out, nOut, exp_out(k, 6));
      end
    end
  endtask

  task automatic test_async_reset();
    go_idle();
    dutyCycle = 8'd128;
    enable = 1'b1;
    tick();
    tick();
    #10;
    rst = 1'b0;
    #5;
    tests++;
    if (out !== 1'b0 || nOut !== 1'b1) begin
      fails++;
      $display("FAIL async_reset: out=%b nOut=%b want 0/1", out, nOut);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      tests++;
      if (out !== exp_out(k, 6) || nOut !== ~exp_out(k, 6)) begin
        fails++;
        $display("FAIL post_reset cyc%0d: out=%b nOut=%b want out=%b",
                 k, out, nOut, exp_out(k, 6));
      end
    end
  endtask

  task automatic test_long();
    int   periods;
    int   bad;
    int   run_len;
    int   max_run;
    logic prev;
    go_idle();
    dutyCycle = 8'd128;
    enable = 1'b1;
    periods = 0;
    bad = 0;
    run_len = 0;
    max_run = 0;
    prev = 1'b0;
    for (int k = 0; k < 12000; k++) begin
      tick();
      if (out !== exp_out(k, 6) || nOut !== ~out)
        bad++;
      if (out === 1'b1 && prev === 1'b0)
        periods++;
      if (out === 1'b1) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      prev = out;
    end
    tests++;
    if (periods != 1000) begin
      fails++;
      $display("FAIL long_periods: got %0d want 1000", periods);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL long_pattern: %0d bad cycles want 0", bad);
    end
    tests++;
    if (max_run != 6) begin
      fails++;
      $display("FAIL long_max_high: got %0d want 6", max_run);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    enable = 1'b0;
    dutyCycle = 8'd0;
    test_reset();
    test_d50();
    test_d128_change();
    test_extremes();
    test_enable();
    test_async_reset();
    test_long();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
